// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU types for the hazard scheduler.
// State encoding, register specifier type, MDU latency default.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MDU_BUSY = 2'd1,
        HZ_MDU_DONE = 2'd2
    } hz_state_t;

    typedef logic [4:0] reg_id_t;

    localparam int unsigned MDU_CYCLES_DEF = 32;

endpackage

// File: rtl/hz_loaduse_detect.sv
// Load-use hazard compare between the EX load and the ID sources.
// Register 0 is hardwired and never creates a dependency.
module hz_loaduse_detect
    import hazard_ctrl_pkg::*;
(
    input  reg_id_t id_rs,
    input  reg_id_t id_rt,
    input  logic    id_use_rs,
    input  logic    id_use_rt,
    input  logic    ex_memread,
    input  reg_id_t ex_rd,
    output logic    lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_use_rs && (id_rs == ex_rd);
    assign rt_hit = id_use_rt && (id_rt == ex_rd);
    assign lu     = ex_memread && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the five-stage pipe.
// Arbitrates load-use, redirect, MDU sequencing and memory wait.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MDU_CYCLES = MDU_CYCLES_DEF,
    parameter int unsigned CNT_W      = $clog2(MDU_CYCLES)
) (
    input  logic    clk,
    input  logic    rst,
    input  reg_id_t id_rs,
    input  reg_id_t id_rt,
    input  logic    id_use_rs,
    input  logic    id_use_rt,
    input  logic    ex_memread,
    input  reg_id_t ex_rd,
    input  logic    id_is_mdu,
    input  logic    id_redirect,
    input  logic    mem_wait,
    output logic    pc_en,
    output logic    ifid_en,
    output logic    ifid_flush,
    output logic    idex_en,
    output logic    idex_flush,
    output logic    exmem_en,
    output logic    mdu_start,
    output logic    mdu_busy
);

    hz_state_t        state;
    hz_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             lu;

    logic pc_r, ifid_r, ifidf_r, idex_r;
    logic idexf_r, exmem_r, start_r, busy_r;

    hz_loaduse_detect u_lu (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .lu         (lu)
    );

    // State and countdown registers; reset aborts any MDU sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HZ_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: launch, count down to zero, release; mem_wait holds all.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            HZ_RUN: begin
                if (!mem_wait && !lu && id_is_mdu) begin
                    state_nx = HZ_MDU_BUSY;
                    cnt_nx   = CNT_W'(MDU_CYCLES - 2);
                end
            end
            HZ_MDU_BUSY: begin
                if (!mem_wait) begin
                    if (cnt == '0) state_nx = HZ_MDU_DONE;
                    else           cnt_nx   = cnt - 1'b1;
                end
            end
            HZ_MDU_DONE: begin
                if (!mem_wait) state_nx = HZ_RUN;
            end
            default: begin
                state_nx = HZ_RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    // Enables and flushes per state, highest-priority hazard first.
    always_comb begin
        pc_r    = 1'b0;
        ifid_r  = 1'b0;
        ifidf_r = 1'b0;
        idex_r  = 1'b0;
        idexf_r = 1'b0;
        exmem_r = 1'b0;
        start_r = 1'b0;
        busy_r  = 1'b0;
        unique case (state)
            HZ_RUN: begin
                if (mem_wait) begin
                    pc_r = 1'b0;
                end else if (lu || id_is_mdu) begin
                    idex_r  = 1'b1;
                    idexf_r = 1'b1;
                    exmem_r = 1'b1;
                    start_r = !lu;
                end else begin
                    pc_r    = 1'b1;
                    ifid_r  = 1'b1;
                    idex_r  = 1'b1;
                    exmem_r = 1'b1;
                    ifidf_r = id_redirect;
                end
            end
            HZ_MDU_BUSY: begin
                busy_r = 1'b1;
                if (!mem_wait) begin
                    idex_r  = 1'b1;
                    idexf_r = 1'b1;
                    exmem_r = 1'b1;
                end
            end
            HZ_MDU_DONE: begin
                if (!mem_wait) begin
                    pc_r    = 1'b1;
                    ifid_r  = 1'b1;
                    idex_r  = 1'b1;
                    exmem_r = 1'b1;
                end
            end
            default: begin
                pc_r = 1'b0;
            end
        endcase
    end

    assign pc_en      = rst && pc_r;
    assign ifid_en    = rst && ifid_r;
    assign ifid_flush = rst && ifidf_r;
    assign idex_en    = rst && idex_r;
    assign idex_flush = rst && idexf_r;
    assign exmem_en   = rst && exmem_r;
    assign mdu_start  = rst && start_r;
    assign mdu_busy   = rst && busy_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// Directed scenarios plus random traffic against a cycle-budget model.
module tb_hazard_ctrl;

    localparam int M = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, ex_memread;
    logic       id_is_mdu, id_redirect, mem_wait;
    logic       pc_en, ifid_en, ifid_flush, idex_en;
    logic       idex_flush, exmem_en, mdu_start, mdu_busy;
    logic [7:0] outv;

    int checks = 0;
    int errors = 0;
    // cycles left in the MDU sequence, counting the release cycle
    int left = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_CYCLES(M)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .id_is_mdu(id_is_mdu), .id_redirect(id_redirect),
        .mem_wait(mem_wait),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .mdu_start(mdu_start),
        .mdu_busy(mdu_busy)
    );

    assign outv = {pc_en, ifid_en, ifid_flush, idex_en,
                   idex_flush, exmem_en, mdu_start, mdu_busy};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_lu();
        return ex_memread && ex_rd != 0 &&
               ((id_use_rs && id_rs == ex_rd) ||
                (id_use_rt && id_rt == ex_rd));
    endfunction

    // {pc,ifid,ifid_fl,idex,idex_fl,exmem,start,busy}
    function automatic logic [7:0] model_out();
        if (!rst) return 8'b0;
        if (left > 1)
            return mem_wait ? 8'b0000_0001 : 8'b0001_1101;
        if (left == 1)
            return mem_wait ? 8'b0 : 8'b1101_0100;
        if (mem_wait) return 8'b0;
        if (model_lu()) return 8'b0001_1100;
        if (id_is_mdu) return 8'b0001_1110;
        if (id_redirect) return 8'b1111_0100;
        return 8'b1101_0100;
    endfunction

    task automatic model_step();
        if (!rst) left = 0;
        else if (mem_wait) left = left;
        else if (left > 0) left = left - 1;
        else if (!model_lu() && id_is_mdu) left = M;
    endtask

    // called at negedge + settle; checks, crosses posedge, returns at negedge
    task automatic tick(input string tag);
        chk(tag, outv, model_out());
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_use_rs = 0; id_use_rt = 0; ex_memread = 0;
        id_is_mdu = 0; id_redirect = 0; mem_wait = 0;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        idle();
        @(negedge clk);
        #1;
        chk("rst_out", outv, 8'h00);
        tick("rst");
        tick("rst");
        rst = 1'b1;
        #1;
        chk("run_pc", pc_en, 1);
        tick("idle");

        // load-use on rs
        ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
        #1;
        chk("lu_pc", pc_en, 0);
        chk("lu_idexfl", idex_flush, 1);
        tick("lu");
        idle();
        #1;
        chk("lu_after", pc_en, 1);
        tick("lu_after");

        // register zero never hazards
        ex_memread = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
        #1;
        chk("r0_pc", pc_en, 1);
        tick("r0");
        idle();

        // MDU freeze length
        id_is_mdu = 1;
        #1;
        chk("mdu_start", mdu_start, 1);
        n = 0;
        while (!pc_en && n < 50) begin
            n++;
            tick("mdu");
            if (n > 0) chk("mdu_nostart", mdu_start, 0);
        end
        chk("mdu_freeze", n, M);
        chk("mdu_done_busy", mdu_busy, 0);
        id_is_mdu = 0;
        #1;
        tick("mdu_done");

        // redirect suppressed by load-use, taken next cycle
        id_redirect = 1; ex_memread = 1; ex_rd = 5;
        id_rt = 5; id_use_rt = 1;
        #1;
        chk("rd_lu_fl", ifid_flush, 0);
        chk("rd_lu_pc", pc_en, 0);
        tick("rd_lu");
        ex_memread = 0;
        #1;
        chk("rd_fl", ifid_flush, 1);
        chk("rd_pc", pc_en, 1);
        tick("rd");
        idle();

        // mem_wait for three cycles inside MDU_BUSY
        id_is_mdu = 1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            mem_wait = (i >= 2 && i <= 4);
            #1;
            if (pc_en) break;
            if (mem_wait) chk("mw_en", outv, 8'h01);
            n++;
            tick("mdu_mw");
        end
        chk("mw_freeze", n, M + 3);
        idle();
        #1;
        tick("mw_done");

        // reset in the middle of MDU_BUSY
        id_is_mdu = 1;
        #1;
        tick("rm_launch");
        id_is_mdu = 0;
        #1;
        tick("rm_busy");
        rst = 1'b0;
        #1;
        chk("rm_zero", outv, 8'h00);
        tick("rm_rst");
        rst = 1'b1;
        #1;
        chk("rm_pc", pc_en, 1);
        chk("rm_busy0", mdu_busy, 0);
        tick("rm_run");

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) != 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom);
            id_use_rt   = 1'($urandom);
            ex_memread  = ($urandom_range(0, 9) < 4);
            id_is_mdu   = ($urandom_range(0, 9) == 0);
            id_redirect = ($urandom_range(0, 3) == 0);
            mem_wait    = ($urandom_range(0, 4) == 0);
            #1;
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush scheduler for the five-stage CPU. It drives the PC update enable (the ID-level "nostall" that gates NPC into IF_PC) and the IF/ID, ID/EX and EX/MEM register enables and flushes. It arbitrates between four hazard sources: load-use, taken branch/jump redirect, a multi-cycle multiply/divide unit (MDU) and data-memory wait. The MDU sequencing (start pulse, busy countdown) lives here.

## Interface
- `MDU_CYCLES`, default 32: MDU latency in cycles from `mdu_start` to the result being valid; legal range 2..255.
- `CNT_W`, default `$clog2(MDU_CYCLES)`: countdown width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` in 5: source register specifiers of the instruction in ID.
- `id_use_rs`, `id_use_rt` in 1: the ID instruction reads rs / rt.
- `ex_memread` in 1: the instruction in EX is a load.
- `ex_rd` in 5: destination of the EX instruction.
- `id_is_mdu` in 1: the ID instruction is mult/div.
- `id_redirect` in 1: branch taken or jump resolved in ID.
- `mem_wait` in 1: data memory not ready; the whole pipe freezes.
- `pc_en` out 1: PC load enable.
- `ifid_en` out 1: IF/ID register enable.
- `ifid_flush` out 1: IF/ID register flush.
- `idex_en` out 1: ID/EX register enable.
- `idex_flush` out 1: ID/EX register flush.
- `exmem_en` out 1: EX/MEM register enable.
- `mdu_start` out 1: one-cycle MDU launch pulse.
- `mdu_busy` out 1: MDU operation in progress.

## Operation
- Load-use hazard: `lu = ex_memread & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd))`. Register 0 never hazards.
- FSM states are RUN, MDU_BUSY and MDU_DONE. Reset state is RUN with count 0.
- **RUN**, with priority highest first:
  - `mem_wait`: all enables 0, all flushes 0, no state change.
  - `lu`: `pc_en=0`, `ifid_en=0`, `idex_flush=1`. Redirect and MDU launch are suppressed this cycle.
  - `id_is_mdu`: `mdu_start=1`, `pc_en=0`, `ifid_en=0`, `idex_flush=1`. Count loads `MDU_CYCLES-2`, go to MDU_BUSY.
  - `id_redirect` alone: all enables 1, `ifid_flush=1`.
  - Otherwise all enables 1 and all flushes 0.
- **MDU_BUSY**:
  - `mdu_busy=1`, `pc_en=0`, `ifid_en=0`, `idex_flush=1`, `exmem_en=1`, so older instructions drain.
  - Count decrements each cycle. When count is 0, go to MDU_DONE.
  - `mem_wait` freezes both the count and the enables.
- **MDU_DONE**:
  - `mdu_busy=0`. The held MDU instruction advances with all enables 1.
  - `id_is_mdu` is ignored because it is the same instruction.
  - `id_redirect` is not possible, since an MDU instruction is not a branch.
  - Go to RUN. A `mem_wait` here holds the state in MDU_DONE.
- `rst` low mid-operation aborts the MDU sequence immediately: state RUN, count 0.

## Timing
- All outputs are combinational from state and inputs, and are valid in the same cycle as the hazard.
- While `rst` is low, every output is 0.
- From an MDU launch at cycle N, `mdu_busy` is 1 for cycles N+1..N+`MDU_CYCLES`-1. MDU_DONE falls at N+`MDU_CYCLES`.
- Total PC freeze for an MDU instruction is `MDU_CYCLES` cycles.
- A load-use stall is exactly one cycle unless `mem_wait` intervenes, because the load leaves EX.
- Count arithmetic is unsigned `CNT_W` bits and never wraps: decrement only occurs when count > 0.

## Structure
- Shared CPU package holds:
  - the state enum (`HZ_RUN`, `HZ_MDU_BUSY`, `HZ_MDU_DONE`);
  - the 5-bit register-specifier type;
  - the `MDU_CYCLES` default.
- One natural sub-module, `hz_loaduse_detect`, holds the combinational `lu` compare. The FSM and counter stay in `hazard_ctrl`.

## Test plan
- **Load-use:** `ex_memread=1`, `ex_rd=8`, `id_rs=8`, `id_use_rs=1` for one cycle -> that cycle `pc_en=0`, `ifid_en=0`, `idex_flush=1`. Next cycle all enables 1.
- **Register 0:** repeat with `ex_rd=0` -> no stall.
- **MDU, `MDU_CYCLES=4`:** `id_is_mdu` at cycle N -> `mdu_start=1` at N only, `mdu_busy` at N+1..N+3, `pc_en=0` at N..N+3, `pc_en=1` at N+4.
- **Redirect vs load-use:** `id_redirect=1` together with a load-use hazard -> stall with no `ifid_flush`. The next cycle with the hazard gone gives `ifid_flush=1`, `pc_en=1`.
- **`mem_wait` during MDU_BUSY:** assert for 3 cycles -> all enables 0 and count frozen. The MDU completes 3 cycles later than nominal.
- **Reset mid-MDU:** pull `rst` low during MDU_BUSY -> all outputs 0 immediately. After release, RUN with `pc_en=1` and `mdu_busy=0`.
